// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - event counters with freeze-on-halt, saturation flags and registered read port
module perf_counter_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             halted,
    output logic [5:0]       ovf,
    output logic             proto_err
);

    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_FROZEN   = 1'b1
    } state_e;

    localparam int NUM_CNT = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [5:0]       ovf_q, ovf_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [5:0]       inc;
    logic [CNT_W-1:0] status_word;

    // Per-counter increment requests, ordered to match rd_sel 0..5
    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = halt | reg_write | mem_write;
        inc[2] = icache_req;
        inc[3] = icache_hit;
        inc[4] = dcache_req;
        inc[5] = dcache_hit;
    end

    // Counter, flag and state update; clear wins over everything including halt
    always_comb begin
        state_d     = state_q;
        ovf_d       = ovf_q;
        proto_err_d = proto_err_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clear) begin
            state_d     = ST_COUNTING;
            ovf_d       = '0;
            proto_err_d = 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_d[i] = '0;
            end
        end else if (state_q == ST_COUNTING) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            end
            if ((icache_hit & ~icache_req) | (dcache_hit & ~dcache_req)) begin
                proto_err_d = 1'b1;
            end
            if (halt) begin
                state_d = ST_FROZEN;
            end
        end
    end

    // Read mux samples pre-update values so a read alongside clear sees the old count
    always_comb begin
        status_word      = '0;
        status_word[7:0] = {proto_err_q, (state_q == ST_FROZEN), ovf_q};
        rd_valid_d       = rd_en;
        rd_data_d        = rd_data_q;
        if (rd_en) begin
            case (rd_sel)
                3'd0:    rd_data_d = cnt_q[0];
                3'd1:    rd_data_d = cnt_q[1];
                3'd2:    rd_data_d = cnt_q[2];
                3'd3:    rd_data_d = cnt_q[3];
                3'd4:    rd_data_d = cnt_q[4];
                3'd5:    rd_data_d = cnt_q[5];
                3'd6:    rd_data_d = status_word;
                default: rd_data_d = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COUNTING;
            ovf_q       <= '0;
            proto_err_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            proto_err_q <= proto_err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign halted    = (state_q == ST_FROZEN);
    assign ovf       = ovf_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb/tb_perf_counter_unit.sv - randomized and directed checks of perf_counter_unit against a behavioural model
module tb_perf_counter_unit;

    logic clk = 1'b0;
    logic rst, halt, reg_write, mem_write, icache_req, icache_hit, dcache_req, dcache_hit, clear, rd_en;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data_w;
    logic [7:0]  rd_data_n;
    logic        rd_valid_w, rd_valid_n, halted_w, halted_n, perr_w, perr_n;
    logic [5:0]  ovf_w, ovf_n;

    always #5 clk = ~clk;

    perf_counter_unit #(.CNT_W(32)) u_dut_wide (
        .clk(clk), .rst(rst), .halt(halt), .reg_write(reg_write), .mem_write(mem_write),
        .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
        .dcache_hit(dcache_hit), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .halted(halted_w), .ovf(ovf_w),
        .proto_err(perr_w)
    );

    perf_counter_unit #(.CNT_W(8)) u_dut_narrow (
        .clk(clk), .rst(rst), .halt(halt), .reg_write(reg_write), .mem_write(mem_write),
        .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
        .dcache_hit(dcache_hit), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_n), .rd_valid(rd_valid_n), .halted(halted_n), .ovf(ovf_n),
        .proto_err(perr_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 = 32-bit instance, index 1 = 8-bit instance
    longint unsigned m_cnt [2][6];
    longint unsigned m_max [2];
    logic [5:0]      m_ovf [2];
    longint unsigned m_rd_data [2];
    logic            m_perr, m_frozen, m_rd_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
            m_ovf[k] = '0;
        end
        m_perr   = 1'b0;
        m_frozen = 1'b0;
    endtask

    function automatic longint unsigned sel_value(input int k, input logic [2:0] s);
        case (s)
            3'd6:    return {56'd0, m_perr, m_frozen, m_ovf[k]};
            3'd7:    return 0;
            default: return m_cnt[k][s];
        endcase
    endfunction

    // Advance one clock: predict from current inputs, then compare all outputs after the edge
    task automatic tick();
        logic [5:0] ev;
        ev = {dcache_hit, dcache_req, icache_hit, icache_req, (halt | reg_write | mem_write), 1'b1};
        if (rst) begin
            model_zero();
            m_rd_valid   = 1'b0;
            m_rd_data[0] = 0;
            m_rd_data[1] = 0;
        end else begin
            m_rd_valid = rd_en;
            if (rd_en) begin
                for (int k = 0; k < 2; k++) m_rd_data[k] = sel_value(k, rd_sel);
            end
            if (clear) begin
                model_zero();
            end else if (!m_frozen) begin
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i < 6; i++) begin
                        if (ev[i]) begin
                            if (m_cnt[k][i] == m_max[k]) m_ovf[k][i] = 1'b1;
                            else m_cnt[k][i] = m_cnt[k][i] + 1;
                        end
                    end
                end
                if ((icache_hit && !icache_req) || (dcache_hit && !dcache_req)) m_perr = 1'b1;
                if (halt) m_frozen = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("rd_valid_w", {63'd0, rd_valid_w}, {63'd0, m_rd_valid});
        check("rd_valid_n", {63'd0, rd_valid_n}, {63'd0, m_rd_valid});
        check("rd_data_w", {32'd0, rd_data_w}, m_rd_data[0]);
        check("rd_data_n", {56'd0, rd_data_n}, m_rd_data[1]);
        check("ovf_w", {58'd0, ovf_w}, {58'd0, m_ovf[0]});
        check("ovf_n", {58'd0, ovf_n}, {58'd0, m_ovf[1]});
        check("halted_w", {63'd0, halted_w}, {63'd0, m_frozen});
        check("halted_n", {63'd0, halted_n}, {63'd0, m_frozen});
        check("perr_w", {63'd0, perr_w}, {63'd0, m_perr});
        check("perr_n", {63'd0, perr_n}, {63'd0, m_perr});
    endtask

    task automatic set_idle();
        rst = 0; halt = 0; reg_write = 0; mem_write = 0; icache_req = 0; icache_hit = 0;
        dcache_req = 0; dcache_hit = 0; clear = 0; rd_en = 0; rd_sel = 3'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    // Directed read with fixed expectations for both widths
    task automatic read_exp(input string tag, input logic [2:0] s, input longint unsigned exp_w,
                            input longint unsigned exp_n);
        rd_en = 1; rd_sel = s;
        tick();
        rd_en = 0;
        check({tag, "_w"}, {32'd0, rd_data_w}, exp_w);
        check({tag, "_n"}, {56'd0, rd_data_n}, exp_n);
    endtask

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 64'hFF;
        model_zero();
        m_rd_valid   = 1'b0;
        m_rd_data[0] = 0;
        m_rd_data[1] = 0;
        set_idle();

        // Reset state
        rst = 1; tick(); tick(); rst = 0;
        check("reset_rd_data", {32'd0, rd_data_w}, 64'd0);
        check("reset_halted", {63'd0, halted_w}, 64'd0);
        check("reset_ovf", {58'd0, ovf_w}, 64'd0);

        // Ten idle cycles then cycle count readback
        idle(10);
        read_exp("idle_cycles", 3'd0, 10, 10);
        tick();
        check("rd_valid_pulse", {63'd0, rd_valid_w}, 64'd0);
        read_exp("idle_insts", 3'd1, 0, 0);
        read_exp("idle_ireq", 3'd2, 0, 0);
        read_exp("idle_dhit", 3'd5, 0, 0);

        // Coincident retire events count once
        do_clear();
        reg_write = 1; mem_write = 1;
        idle(5);
        reg_write = 0; mem_write = 0;
        read_exp("single_inst", 3'd1, 5, 5);

        // Events up to and including halt, then frozen
        do_clear();
        dcache_req = 1; dcache_hit = 1;
        idle(3);
        dcache_req = 0; dcache_hit = 0;
        halt = 1; icache_req = 1;
        tick();
        reg_write = 1; mem_write = 1; icache_hit = 1; dcache_req = 1; dcache_hit = 1;
        idle(4);
        set_idle();
        read_exp("halt_dreq", 3'd4, 3, 3);
        read_exp("halt_dhit", 3'd5, 3, 3);
        read_exp("halt_ireq", 3'd2, 1, 1);
        read_exp("halt_insts", 3'd1, 1, 1);
        read_exp("halt_cycles", 3'd0, 4, 4);
        read_exp("halt_status", 3'd6, 64'h40, 64'h40);
        read_exp("sel7", 3'd7, 0, 0);

        // Saturation of the narrow data-request counter
        do_clear();
        dcache_req = 1;
        idle(300);
        dcache_req = 0;
        read_exp("sat_dreq", 3'd4, 300, 255);
        check("sat_ovf4", {63'd0, ovf_n[4]}, 64'd1);
        check("sat_ovf_other", {60'd0, ovf_n[5], ovf_n[3:1]}, 64'd0);
        check("sat_ovf_wide", {58'd0, ovf_w}, 64'd0);

        // Hit without request
        do_clear();
        icache_hit = 1; tick(); icache_hit = 0;
        idle(20);
        check("perr_sticky", {63'd0, perr_w}, 64'd1);
        read_exp("perr_ihit", 3'd3, 1, 1);
        do_clear();
        check("perr_cleared", {63'd0, perr_w}, 64'd0);

        // Clear together with halt, events and a read
        do_clear();
        idle(7);
        clear = 1; halt = 1; reg_write = 1; rd_en = 1; rd_sel = 3'd0;
        tick();
        check("clear_read", {32'd0, rd_data_w}, 64'd7);
        set_idle();
        check("clear_not_halted", {63'd0, halted_w}, 64'd0);
        read_exp("clear_cycles0", 3'd0, 0, 0);
        read_exp("clear_cycles1", 3'd0, 1, 1);

        // Reset mid-count
        idle(5);
        rst = 1; tick(); rst = 0;
        read_exp("rst_cycles", 3'd0, 0, 0);
        read_exp("rst_insts", 3'd1, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            halt       = ($urandom_range(0, 49) == 0);
            reg_write  = $urandom_range(0, 1);
            mem_write  = ($urandom_range(0, 3) == 0);
            icache_req = $urandom_range(0, 1);
            icache_hit = icache_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            dcache_req = $urandom_range(0, 1);
            dcache_hit = dcache_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            rd_en      = $urandom_range(0, 1);
            rd_sel     = 3'($urandom_range(0, 7));
            tick();
        end
        set_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
